output_module: RTL

Downstream stage of MergeSorterTree: pops the tree's sorted 32-bit stream, packs 16 consecutive records into 512-bit lines and hands them to the write-back path over a valid/ready handshake. Each run has a programmed record count. The final partial line is padded and flagged. The block checks ascending order on the fly and reports a sticky error.

---
 rtl/sorter_pkg.sv | 20 ++
 rtl/output_module_line_reg.sv | 36 +++
 rtl/output_module.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the merge-sorter output stage.
// Holds record/line geometry, the pad word and the FSM state type.
package sorter_pkg;

  localparam int DATA_W = 32;
  localparam int WORDS  = 16;
  localparam int LINE_W = DATA_W * WORDS;
  localparam int IDX_W  = $clog2(WORDS + 1);
  localparam int SLOT_W = $clog2(WORDS);

  localparam logic [DATA_W-1:0] PAD_WORD = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/output_module_line_reg.sv
// Single-entry 512-bit output register with valid/last and ready handshake.
// Ports: load/line_in/last_in in, line/valid/last out, free = may load now.
module line_out_reg
  import sorter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] line_in,
  input  logic              last_in,
  input  logic              ready,
  output logic [LINE_W-1:0] line,
  output logic              valid,
  output logic              last,
  output logic              free
);

  // Free when empty, or when the held line leaves on this edge.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      line  <= line_in;
      valid <= 1'b1;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/output_module.sv
// Pops the sorted tree stream, packs 16 records per 512-bit line, pads the tail.
// Ports: start/total run control, t_* tree FWFT pop, dout_* line out, status.
module output_module
  import sorter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  total,
  input  logic [DATA_W-1:0] t_dout,
  input  logic              t_empty,
  output logic              t_deq,
  output logic [LINE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              order_err
);

  state_t                        state;
  logic [CNT_W-1:0]              total_r;
  logic [CNT_W-1:0]              popped;
  logic [IDX_W-1:0]              idx;
  logic [WORDS-1:0][DATA_W-1:0]  acc;
  logic [WORDS-1:0][DATA_W-1:0]  line;
  logic [DATA_W-1:0]             prev;

  logic             active;
  logic             all_popped;
  logic             full;
  logic             out_free;
  logic             xfer;
  logic             stall;
  logic [IDX_W-1:0] slot;
  logic [SLOT_W-1:0] wr_pos;

  assign active     = (state == RUN) || (state == DRAIN);
  assign all_popped = (popped == total_r);
  assign full       = (idx == IDX_W'(WORDS));

  // Move the accumulator out when full, or when the run's tail is complete.
  assign xfer  = active && out_free && (full || (all_popped && idx != '0));
  assign stall = full && !xfer;

  assign t_deq = (state == RUN) && !t_empty && !stall && (popped < total_r);

  // A pop coinciding with a transfer starts the next line at slot 0.
  assign slot   = xfer ? '0 : idx;
  assign wr_pos = SLOT_W'(WORDS - 1) - slot[SLOT_W-1:0];

  // Record 0 sits in the top word; slots never written are padded.
  always_comb begin
    line = '0;
    for (int k = 0; k < WORDS; k++) begin
      line[WORDS-1-k] = (IDX_W'(k) < idx) ? acc[WORDS-1-k] : PAD_WORD;
    end
  end

  line_out_reg u_line_out (
    .clk     (clk),
    .rst     (rst),
    .load    (xfer),
    .line_in (line),
    .last_in (all_popped),
    .ready   (dout_ready),
    .line    (dout),
    .valid   (dout_valid),
    .last    (dout_last),
    .free    (out_free)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      total_r   <= '0;
      popped    <= '0;
      idx       <= '0;
      acc       <= '0;
      prev      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      order_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            total_r   <= total;
            popped    <= '0;
            idx       <= '0;
            order_err <= 1'b0;
            if (total == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (t_deq) begin
            acc[wr_pos] <= t_dout;
            idx         <= slot + IDX_W'(1);
            popped      <= popped + CNT_W'(1);
            prev        <= t_dout;
            if (popped != '0 && t_dout < prev) order_err <= 1'b1;
            if (popped + CNT_W'(1) == total_r) state <= DRAIN;
          end else if (xfer) begin
            idx <= '0;
          end
        end
        DRAIN: begin
          if (xfer) idx <= '0;
          if (dout_valid && dout_ready && dout_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
